// File: rtl/ntt_butterfly.sv
// ntt_butterfly
//   Cooley-Tukey butterfly for the Dilithium forward NTT, modulus Q = 8380417.
//   For every issued pair it computes t = zeta*b mod Q, A' = (a + t) mod Q and
//   B' = (a - t) mod Q. The write-back addresses travel alongside the data, so
//   they leave the block aligned with their results.
//   The pipeline has four register stages and accepts one butterfly per cycle.
//   en_i stalls the whole pipeline, and clear_i flushes it. A butterfly counter
//   produces a pulse at the end of each NTT layer.
//
//   Latency: a pair presented with valid_i is captured by one rising edge. It
//   appears on valid_o after the fourth advancing edge, counting the capture
//   edge.
//
// Ports
//   clk_i, rst_i        clock (rising edge); asynchronous active-high reset
//   clear_i             synchronous flush of all valids and the counter; wins over en_i
//   en_i                pipeline advance; 0 freezes every stage
//   valid_i             addr_a_i/addr_b_i/a_i/b_i/zeta_i form a butterfly
//   a_i, b_i, zeta_i    coefficients and twiddle, each < Q
//   valid_o             output stage holds a result
//   wren_o              write strobe = valid_o & en_i & ~clear_i
//   addr_a_o, addr_b_o  write-back addresses for a_o / b_o
//   a_o, b_o            (a + zeta*b) mod Q, (a - zeta*b) mod Q
//   bf_cnt_o            butterflies written in the current layer
//   layer_done_o        pulse with the LAYER_BF-th wren_o of a layer
//   busy_o              any stage holds a valid butterfly
//
// The reduction network is specific to Q = 2^23 - 2^13 + 1 and W = 23.
// It uses the congruence 2^23 == 2^13 - 1 (mod Q).

module ntt_butterfly #(
  parameter int Q        = 8380417,
  parameter int W        = 23,
  parameter int AW       = 8,
  parameter int LAYER_BF = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [W-1:0]  zeta_i,
  output logic          valid_o,
  output logic          wren_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic [7:0]    bf_cnt_o,
  output logic          layer_done_o,
  output logic          busy_o
);

  localparam int PW = 2 * W;
  localparam logic [W:0] QX = (W+1)'(Q);
  localparam logic [7:0] CNT_LAST = 8'(LAYER_BF - 1);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic          v1, v2, v3;
  logic [W-1:0]  a1, a2, a3;
  logic [AW-1:0] aa1, aa2, aa3;
  logic [AW-1:0] ab1, ab2, ab3;
  logic [PW-1:0] p1;
  logic [36:0]   f2;
  logic [W-1:0]  t3;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prod_c;
  logic [36:0]   fold1_c;
  logic [27:0]   fold2_c;
  logic [W:0]    fold3_c;
  logic [W-1:0]  t_c;
  logic [W:0]    sum_c;
  logic [W-1:0]  a_res_c;
  logic [W-1:0]  b_res_c;

  assign prod_c = PW'(zeta_i) * PW'(b_i);

  // First fold: p = ph*2^23 + pl, which is congruent to ph*2^13 - ph + pl.
  // This is never negative because ph*2^13 >= ph. The result is below
  // 2^36 + 2^23, so 37 bits hold it.
  assign fold1_c = {1'b0, p1[45:23], 13'b0} + {14'b0, p1[22:0]} - {14'b0, p1[45:23]};

  // Stage 3 folds twice more and then does one conditional subtract.
  //   Second fold: input < 2^37, so the high part is 14 bits and the result
  //                is < 2^27 + 2^23.
  //   Third fold:  the high part is 5 bits and the result is
  //                < 2^23 + 2^18 < 2Q.
  always_comb begin
    fold2_c = {1'b0, f2[36:23], 13'b0} + {5'b0, f2[22:0]} - {14'b0, f2[36:23]};
    fold3_c = {6'b0, fold2_c[27:23], 13'b0} + {1'b0, fold2_c[22:0]}
              - {19'b0, fold2_c[27:23]};
    if (fold3_c >= QX) t_c = W'(fold3_c - QX);
    else               t_c = fold3_c[W-1:0];
  end

  always_comb begin
    sum_c = {1'b0, a3} + {1'b0, t3};
    if (sum_c >= QX) a_res_c = W'(sum_c - QX);
    else             a_res_c = sum_c[W-1:0];
    if (a3 >= t3) b_res_c = a3 - t3;
    else          b_res_c = W'({1'b0, a3} + QX - {1'b0, t3});
  end

  // ---------------------------------------------------------------------------
  // Valid chain: clear_i kills every valid regardless of en_i
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      valid_o <= 1'b0;
    end else if (clear_i) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      valid_o <= 1'b0;
    end else if (en_i) begin
      v1      <= valid_i;
      v2      <= v1;
      v3      <= v2;
      valid_o <= v3;
    end
  end

  // ---------------------------------------------------------------------------
  // Data and address registers. They are not flushed by clear_i, because
  // their contents only matter when the matching valid bit is set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a1       <= '0;
      aa1      <= '0;
      ab1      <= '0;
      p1       <= '0;
      a2       <= '0;
      aa2      <= '0;
      ab2      <= '0;
      f2       <= '0;
      a3       <= '0;
      aa3      <= '0;
      ab3      <= '0;
      t3       <= '0;
      a_o      <= '0;
      b_o      <= '0;
      addr_a_o <= '0;
      addr_b_o <= '0;
    end else if (en_i) begin
      a1       <= a_i;
      aa1      <= addr_a_i;
      ab1      <= addr_b_i;
      p1       <= prod_c;
      a2       <= a1;
      aa2      <= aa1;
      ab2      <= ab1;
      f2       <= fold1_c;
      a3       <= a2;
      aa3      <= aa2;
      ab3      <= ab2;
      t3       <= t_c;
      a_o      <= a_res_c;
      b_o      <= b_res_c;
      addr_a_o <= aa3;
      addr_b_o <= ab3;
    end
  end

  // ---------------------------------------------------------------------------
  // Write strobe, layer counter, status
  // ---------------------------------------------------------------------------
  assign wren_o       = valid_o & en_i & ~clear_i;
  assign layer_done_o = wren_o & (bf_cnt_o == CNT_LAST);
  assign busy_o       = v1 | v2 | v3 | valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bf_cnt_o <= 8'd0;
    end else if (clear_i) begin
      bf_cnt_o <= 8'd0;
    end else if (wren_o) begin
      if (layer_done_o) bf_cnt_o <= 8'd0;
      else              bf_cnt_o <= bf_cnt_o + 8'd1;
    end
  end

endmodule
